sm83_bus_responder: RTL and testbench

// Responder (memory/peripheral) end of the SM83 external data-bus protocol, for system-level sims
// of the gate-level core. Samples CPU read/write strobes and address, inserts a programmable

---
 rtl/sm83_bus_responder.sv | 152 +++++++++++++++
 tb/tb_sm83_bus_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm83_bus_responder.sv
`default_nettype none
// ============================================================================
// Module  : sm83_bus_responder
// Brief   : Memory/peripheral responder for the SM83 external data bus.
//           Accepts one strobe, waits WAIT_T cycles, acks, holds until release.
// Rev     : 1.0  initial release
// ============================================================================
module sm83_bus_responder #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int WAIT_T     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_dout,
    output logic [DATA_W-1:0] rsp_din,
    output logic              rsp_drv,
    output logic              rsp_ack,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;
    localparam logic [1:0] c_st_hold = 2'd3;
    localparam logic [3:0] c_wait    = 4'(WAIT_T);
    localparam int         c_depth   = 1 << DEPTH_LOG2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic                  r_is_wr;
    logic                  r_rd_q;
    logic                  r_wr_q;
    logic [DATA_W-1:0]     r_mem [c_depth];

    logic w_accept;
    logic w_ack_nxt;
    logic w_err_nxt;
    logic w_drv_set;
    logic w_drv_clr;
    logic w_mem_we;
    logic w_strobe;
    logic w_opp_rise;
    logic w_both_rise;
    logic w_unused_addr;

    // Upper address bits alias onto the store.
    assign w_unused_addr = ^cpu_addr[ADDR_W-1:DEPTH_LOG2];

    assign w_strobe    = r_is_wr ? cpu_wr : cpu_rd;
    assign w_opp_rise  = r_is_wr ? (cpu_rd & ~r_rd_q) : (cpu_wr & ~r_wr_q);
    assign w_both_rise = cpu_rd & cpu_wr & ~(r_rd_q & r_wr_q);
    assign busy        = (r_state != c_st_idle);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_drv_set   = 1'b0;
        w_drv_clr   = 1'b0;
        w_mem_we    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (cpu_rd && cpu_wr) begin
                    // Flag contention once, not for every cycle it persists.
                    w_err_nxt = w_both_rise;
                end else if (cpu_rd || cpu_wr) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = c_wait;
                    w_state_nxt = (c_wait == 4'd0) ? c_st_resp : c_st_wait;
                end
            end
            c_st_wait: begin
                if (!w_strobe) begin
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = c_st_idle;
                end else begin
                    // Leave on the decrement that reaches zero so ack lands WAIT_T+1 after accept.
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = c_st_resp;
                    end
                end
            end
            c_st_resp: begin
                w_ack_nxt   = 1'b1;
                w_drv_set   = ~r_is_wr;
                w_mem_we    = r_is_wr;
                w_state_nxt = c_st_hold;
            end
            default: begin
                w_err_nxt = w_opp_rise;
                if (!w_strobe) begin
                    w_drv_clr   = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_is_wr <= 1'b0;
            r_rd_q  <= 1'b0;
            r_wr_q  <= 1'b0;
            rsp_din <= '0;
            rsp_drv <= 1'b0;
            rsp_ack <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rd_q  <= cpu_rd;
            r_wr_q  <= cpu_wr;
            rsp_ack <= w_ack_nxt;
            rsp_err <= w_err_nxt;
            if (w_accept) begin
                r_addr  <= cpu_addr[DEPTH_LOG2-1:0];
                r_is_wr <= cpu_wr;
            end
            if (w_drv_set) begin
                rsp_drv <= 1'b1;
                rsp_din <= r_mem[r_addr];
            end else if (w_drv_clr) begin
                rsp_drv <= 1'b0;
            end
        end
    end

    // Store survives reset; an aborted transfer never reaches RESP so never writes.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= cpu_dout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sm83_bus_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_sm83_bus_responder
// Brief   : Four responders (WAIT_T 0,1,3,4) driven by directed and random
//           transfers, checked against a timing/memory reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sm83_bus_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_a   [4];
    logic        wr_a   [4];
    logic [15:0] addr_a [4];
    logic [7:0]  dout_a [4];
    logic [7:0]  din_a  [4];
    logic        drv_a  [4];
    logic        ack_a  [4];
    logic        err_a  [4];
    logic        busy_a [4];

    logic [7:0]  mem_m [4][256];
    bit          val_m [4][256];
    int          nvec  = 0;
    int          nfail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sm83_bus_responder #(
            .WAIT_T(g == 0 ? 0 : (g == 1 ? 1 : (g == 2 ? 3 : 4)))
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .cpu_rd  (rd_a[g]),
            .cpu_wr  (wr_a[g]),
            .cpu_addr(addr_a[g]),
            .cpu_dout(dout_a[g]),
            .rsp_din (din_a[g]),
            .rsp_drv (drv_a[g]),
            .rsp_ack (ack_a[g]),
            .rsp_err (err_a[g]),
            .busy    (busy_a[g])
        );
    end

    function automatic int wt(input int k);
        case (k)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full transfer starting and ending at a negedge; h = extra cycles strobe held after ack.
    task automatic xfer(input int k, input bit w, input logic [15:0] a,
                        input logic [7:0] d, input int h);
        int         n;
        logic [7:0] seen;
        n = wt(k);
        addr_a[k] = a;
        dout_a[k] = d;
        if (w) wr_a[k] = 1'b1; else rd_a[k] = 1'b1;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            chk("ack_early", 32'(ack_a[k]), 32'd0);
            chk("busy_xfer", 32'(busy_a[k]), 32'd1);
        end
        @(negedge clk);
        chk("ack_time", 32'(ack_a[k]), 32'd1);
        chk("err_on_ack", 32'(err_a[k]), 32'd0);
        chk("drv_on_ack", 32'(drv_a[k]), 32'(!w));
        if (!w && val_m[k][a[7:0]]) chk("rd_data", 32'(din_a[k]), 32'(mem_m[k][a[7:0]]));
        seen = din_a[k];
        if (w) begin
            mem_m[k][a[7:0]] = d;
            val_m[k][a[7:0]] = 1'b1;
        end
        for (int i = 0; i < h; i++) begin
            @(negedge clk);
            chk("ack_single", 32'(ack_a[k]), 32'd0);
            chk("drv_hold", 32'(drv_a[k]), 32'(!w));
            if (!w) chk("din_stable", 32'(din_a[k]), 32'(seen));
        end
        rd_a[k] = 1'b0;
        wr_a[k] = 1'b0;
        @(negedge clk);
        chk("drv_release", 32'(drv_a[k]), 32'd0);
        chk("busy_release", 32'(busy_a[k]), 32'd0);
    endtask

    // Start a transfer, then assert reset two cycles in (still waiting).
    task automatic reset_mid(input int k, input bit w, input logic [15:0] a, input logic [7:0] d);
        addr_a[k] = a;
        dout_a[k] = d;
        if (w) wr_a[k] = 1'b1; else rd_a[k] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("busy_pre_rst", 32'(busy_a[k]), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_ack", 32'(ack_a[k]), 32'd0);
        chk("rst_err", 32'(err_a[k]), 32'd0);
        chk("rst_drv", 32'(drv_a[k]), 32'd0);
        chk("rst_din", 32'(din_a[k]), 32'd0);
        chk("rst_busy", 32'(busy_a[k]), 32'd0);
        rd_a[k] = 1'b0;
        wr_a[k] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_ack_after_rst", 32'(ack_a[k]), 32'd0);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rd_a[k] = 1'b0; wr_a[k] = 1'b0; addr_a[k] = '0; dout_a[k] = '0;
            for (int j = 0; j < 256; j++) begin
                val_m[k][j] = 1'b0;
                mem_m[k][j] = 8'h00;
            end
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("reset_din", 32'(din_a[k]), 32'd0);
            chk("reset_drv", 32'(drv_a[k]), 32'd0);
            chk("reset_ack", 32'(ack_a[k]), 32'd0);
            chk("reset_err", 32'(err_a[k]), 32'd0);
            chk("reset_busy", 32'(busy_a[k]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Reset mid-wait: read aborts; a write aborts without touching the store.
        reset_mid(2, 1'b0, 16'h0012, 8'h00);
        xfer(2, 1'b1, 16'h0040, 8'h3C, 0);
        reset_mid(2, 1'b1, 16'h0040, 8'hFF);
        xfer(2, 1'b0, 16'h0040, 8'h00, 1);

        // Write then read, one wait cycle.
        xfer(1, 1'b1, 16'h0034, 8'hA5, 0);
        xfer(1, 1'b0, 16'h0034, 8'h00, 2);

        // Zero wait, back-to-back at minimum period.
        xfer(0, 1'b1, 16'h0010, 8'h77, 0);
        xfer(0, 1'b0, 16'h0010, 8'h00, 0);
        xfer(0, 1'b0, 16'h0010, 8'h00, 0);

        // Upper address bits alias.
        xfer(1, 1'b1, 16'h0107, 8'h5A, 0);
        xfer(1, 1'b0, 16'h0007, 8'h00, 0);

        // Both strobes at once in IDLE.
        xfer(3, 1'b1, 16'h0008, 8'h66, 0);
        addr_a[3] = 16'h0008; dout_a[3] = 8'hEE; rd_a[3] = 1'b1; wr_a[3] = 1'b1;
        @(negedge clk);
        chk("both_err", 32'(err_a[3]), 32'd1);
        chk("both_busy", 32'(busy_a[3]), 32'd0);
        chk("both_ack", 32'(ack_a[3]), 32'd0);
        rd_a[3] = 1'b0; wr_a[3] = 1'b0;
        @(negedge clk);
        chk("both_err_pulse", 32'(err_a[3]), 32'd0);
        xfer(3, 1'b0, 16'h0008, 8'h00, 0);

        // Write strobe dropped during wait.
        xfer(3, 1'b1, 16'h0020, 8'h11, 0);
        addr_a[3] = 16'h0020; dout_a[3] = 8'h99; wr_a[3] = 1'b1;
        @(negedge clk);
        chk("drop_busy", 32'(busy_a[3]), 32'd1);
        @(negedge clk);
        wr_a[3] = 1'b0;
        @(negedge clk);
        chk("drop_err", 32'(err_a[3]), 32'd1);
        chk("drop_busy_idle", 32'(busy_a[3]), 32'd0);
        chk("drop_ack", 32'(ack_a[3]), 32'd0);
        @(negedge clk);
        chk("drop_err_pulse", 32'(err_a[3]), 32'd0);
        xfer(3, 1'b0, 16'h0020, 8'h00, 0);

        // Opposite strobe rising during hold of a read.
        addr_a[0] = 16'h0010; rd_a[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("opp_ack", 32'(ack_a[0]), 32'd1);
        chk("opp_din", 32'(din_a[0]), 32'h77);
        wr_a[0] = 1'b1;
        @(negedge clk);
        chk("opp_err", 32'(err_a[0]), 32'd1);
        chk("opp_drv", 32'(drv_a[0]), 32'd1);
        chk("opp_no_ack", 32'(ack_a[0]), 32'd0);
        wr_a[0] = 1'b0; rd_a[0] = 1'b0;
        @(negedge clk);
        chk("opp_release", 32'(drv_a[0]), 32'd0);
        chk("opp_err_pulse", 32'(err_a[0]), 32'd0);

        // Random traffic across all responders.
        for (int n = 0; n < 60; n++) begin
            int         k;
            bit         w;
            logic [15:0] a;
            k = int'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            a = {8'($urandom), 4'h0, 4'($urandom_range(0, 15))};
            xfer(k, w, a, 8'($urandom), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
